// File: rtl/crypt8_pkg.sv
// Shared definitions for the 8-bit byte cipher: FSM encoding, rotation amount,
// round-counter type and the rotate helper also used by the decrypt side.
package crypt8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_ROUNDS = 8;
    localparam int RCNT_W     = $clog2(MAX_ROUNDS);

    typedef logic [RCNT_W-1:0] rcnt_t;

    localparam rcnt_t ROT_AMT = rcnt_t'(3);

    // A shift by 8 on an 8-bit value yields zero, so n == 0 returns x unchanged.
    function automatic logic [7:0] rotl8(input logic [7:0] x, input rcnt_t n);
        return 8'((x << n) | (x >> (4'd8 - {1'b0, n})));
    endfunction

endpackage

// File: rtl/crypt8_round.sv
// One combinational cipher round: mix in the rotated key, then rotate the result.
module crypt8_round
    import crypt8_pkg::*;
(
    input  logic [7:0] x,
    input  logic [7:0] key_snap,
    input  rcnt_t      idx,
    output logic [7:0] x_next
);

    logic [7:0] round_key;

    assign round_key = rotl8(key_snap, idx);
    assign x_next    = rotl8(x ^ round_key, ROT_AMT);

endmodule

// File: rtl/encrypt_stream.sv
// Iterative byte encryptor: accepts plaintext in IDLE, runs one round per clock,
// then holds the ciphertext until the sink takes it.
module encrypt_stream
    import crypt8_pkg::*;
#(
    parameter int ROUNDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  key_in,
    input  logic        key_load,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic [15:0] byte_cnt
);

    localparam rcnt_t LAST_ROUND = rcnt_t'(ROUNDS - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] key_reg;
    logic [7:0] key_snap;
    logic [7:0] x_reg;
    logic [7:0] x_next;
    rcnt_t      round_cnt;
    logic       last_round;

    assign last_round = (round_cnt == LAST_ROUND);

    crypt8_round u_round (
        .x        (x_reg),
        .key_snap (key_snap),
        .idx      (round_cnt),
        .x_next   (x_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (s_valid)    state_next = RUN;
            RUN:     if (last_round) state_next = DONE;
            DONE:    if (m_ready)    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == IDLE);
        busy    = (state == RUN) || (state == DONE);
    end

    // The key snapshot bypasses key_reg so a key loaded on the accept cycle applies to that byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg   <= 8'h00;
            key_snap  <= 8'h00;
            x_reg     <= 8'h00;
            round_cnt <= '0;
            m_data    <= 8'h00;
            m_valid   <= 1'b0;
            byte_cnt  <= 16'h0000;
        end else begin
            if (key_load) begin
                key_reg <= key_in;
            end
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        x_reg     <= s_data;
                        key_snap  <= key_load ? key_in : key_reg;
                        round_cnt <= '0;
                    end
                end
                RUN: begin
                    x_reg     <= x_next;
                    round_cnt <= round_cnt + rcnt_t'(1);
                    if (last_round) begin
                        m_data  <= x_next;
                        m_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        m_valid  <= 1'b0;
                        byte_cnt <= byte_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_stream.sv
// Directed bench for encrypt_stream: hand-computed ciphertexts, stall/hold, key bypass,
// mid-run reset, and a decrypt round-trip over a stalled stream.
module tb_encrypt_stream;

    localparam int ROUNDS = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  key_in;
    logic        key_load;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic [15:0] byte_cnt;

    int total;
    int bad;

    encrypt_stream #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_load (key_load),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .byte_cnt (byte_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        int k;
        k = n % 8;
        return 8'((v << k) | (v >> (8 - k)));
    endfunction

    // Inverse cipher: undo the rounds in reverse order.
    function automatic logic [7:0] decrypt(input logic [7:0] c, input logic [7:0] k);
        logic [7:0] x;
        x = c;
        for (int i = ROUNDS - 1; i >= 0; i--) begin
            x = rotl(x, 5) ^ rotl(k, i);
        end
        return x;
    endfunction

    task automatic loadKey(input logic [7:0] k);
        key_in   = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Offers one byte, returns at the negedge where m_valid is first seen.
    task automatic applyStimulus(input logic [7:0] data, output logic [7:0] result, output int lat);
        int guard;
        guard   = 0;
        s_data  = data;
        s_valid = 1'b1;
        while (!s_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        lat     = 0;
        while (!m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!m_valid) checkOutput("m_valid_timeout", 32'd0, 32'd1);
        result = m_data;
    endtask

    logic [7:0] r;
    int         lat;
    logic       held;
    logic       seen;
    logic [7:0] stream [5];

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        key_in   = 8'h00;
        key_load = 1'b0;
        s_data   = 8'h00;
        s_valid  = 1'b0;
        m_ready  = 1'b0;
        stream   = '{8'h01, 8'hFE, 8'h86, 8'h3C, 8'h77};

        repeat (3) @(negedge clk);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'h00);
        checkOutput("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic encrypt, key 0x3C");
        m_ready = 1'b1;
        loadKey(8'h3C);
        applyStimulus(8'h86, r, lat);
        checkOutput("t1_data", 32'(r), 32'h68);
        checkOutput("t1_latency", 32'(lat), 32'd4);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        checkOutput("t1_m_valid_drop", 32'(m_valid), 32'd0);
        checkOutput("t1_byte_cnt", 32'(byte_cnt), 32'd1);
        checkOutput("t1_idle", 32'(s_ready), 32'd1);

        $display("[TB] zero key rotation");
        loadKey(8'h00);
        applyStimulus(8'h12, r, lat);
        checkOutput("t2_rot12", 32'(r), 32'h21);
        @(negedge clk);
        applyStimulus(8'h00, r, lat);
        checkOutput("t2_rot00", 32'(r), 32'h00);
        @(negedge clk);
        checkOutput("t2_byte_cnt", 32'(byte_cnt), 32'd3);

        $display("[TB] output stall");
        m_ready = 1'b0;
        loadKey(8'h3C);
        applyStimulus(8'h86, r, lat);
        checkOutput("t3_data", 32'(r), 32'h68);
        s_data  = 8'hAA;
        s_valid = 1'b1;
        held    = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_data !== 8'h68 || s_ready !== 1'b0 || busy !== 1'b1) held = 1'b0;
        end
        checkOutput("t3_hold", 32'(held), 32'd1);
        checkOutput("t3_cnt_stalled", 32'(byte_cnt), 32'd3);
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        checkOutput("t3_release_valid", 32'(m_valid), 32'd0);
        checkOutput("t3_release_idle", 32'(s_ready), 32'd1);
        checkOutput("t3_byte_cnt", 32'(byte_cnt), 32'd4);

        $display("[TB] key bypass and mid-run key load");
        loadKey(8'h00);
        key_in   = 8'h3C;
        key_load = 1'b1;
        s_data   = 8'h86;
        s_valid  = 1'b1;
        @(negedge clk);
        s_valid  = 1'b0;
        key_in   = 8'h00;
        @(negedge clk);
        key_load = 1'b0;
        lat      = 0;
        while (!m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("t4_bypass", 32'(m_data), 32'h68);
        @(negedge clk);
        applyStimulus(8'h12, r, lat);
        checkOutput("t4_key_after", 32'(r), 32'h21);
        @(negedge clk);
        checkOutput("t4_byte_cnt", 32'(byte_cnt), 32'd6);

        $display("[TB] reset during run");
        loadKey(8'h3C);
        s_data  = 8'h86;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_m_valid", 32'(m_valid), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_s_ready", 32'(s_ready), 32'd1);
        checkOutput("t5_byte_cnt", 32'(byte_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (m_valid !== 1'b0) seen = 1'b1;
        end
        checkOutput("t5_no_output", 32'(seen), 32'd0);

        $display("[TB] stalled stream round trip");
        loadKey(8'h5A);
        for (int i = 0; i < 5; i++) begin
            m_ready = 1'b0;
            applyStimulus(stream[i], r, lat);
            checkOutput($sformatf("t6_roundtrip%0d", i), 32'(decrypt(r, 8'h5A)), 32'(stream[i]));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checkOutput($sformatf("t6_hold%0d", i), 32'(m_data), 32'(r));
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
        end
        checkOutput("t6_byte_cnt", 32'(byte_cnt), 32'd5);

        force dut.byte_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.byte_cnt;
        m_ready = 1'b1;
        applyStimulus(8'h86, r, lat);
        checkOutput("t6_wrap_data", 32'(decrypt(r, 8'h5A)), 32'h86);
        @(negedge clk);
        checkOutput("t6_wrap", 32'(byte_cnt), 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
